uart_rx_stream: RTL and testbench

- UART receiver, the receive-side counterpart of the SoC's UART transmitter. Deserialises 8N1 frames from an asynchronous RX pin.
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte stream.
- Sticky error flags are readable by the SoC IO decoder, which maps the stream and flags into the CPU's IO word space.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// State encoding, baud divisor and FIFO index width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a combinational head output.
// Push at full is accepted when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = idx_w(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver feeding a valid/ready byte stream via a FIFO.
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and o_parity_err.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clr_err,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);

  logic            rx_m;
  logic            rx_s;
  rx_state_t       state;
  rx_state_t       state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_n;
  logic [7:0]      shreg;
  logic [7:0]      shreg_n;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            frame_set;
  logic            ovr_set;
  logic            byte_ok;

`ifdef UART_RX_PARITY_EN
  logic            par_bad;
  logic            par_bad_n;
  logic            par_set;

  assign byte_ok = !par_bad;
`else
  assign byte_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    par_set   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_LD;
          state_n = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_s) begin
          state_n = IDLE;
        end else begin
          cnt_n     = FULL_LD;
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          // Line order is LSB first, so shift in from the top.
          shreg_n   = {rx_s, shreg[7:1]};
          cnt_n     = FULL_LD;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          par_bad_n = ((^shreg) ^ rx_s) != PARITY_ODD;
          par_set   = par_bad_n;
          cnt_n     = FULL_LD;
          state_n   = STOP;
        end
`else
        state_n = IDLE;
`endif
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_s) begin
          push    = byte_ok;
          state_n = IDLE;
        end else begin
          frame_set = 1'b1;
          state_n   = BREAK;
        end
      end
      BREAK: begin
        // Hold here until the line returns high.
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_busy  = (state != IDLE);
  assign o_valid = !empty;
  assign pop     = o_valid && i_ready;
  assign ovr_set = push && full && !pop;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (o_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (frame_set) begin
        o_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        o_frame_err <= 1'b0;
      end
      if (ovr_set) begin
        o_overrun <= 1'b1;
      end else if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_parity_err <= 1'b0;
    end else if (par_set) begin
      o_parity_err <= 1'b1;
    end else if (i_clr_err) begin
      o_parity_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Randomised self-checking bench for uart_rx_stream.
// Line frames are built from bit lists; a byte queue models the FIFO.
module tb_uart_rx_stream;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DIV    = 16;
  localparam int DEPTH  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  // stop-bit centre, plus two sync flops, plus one register stage
  localparam int LAT = (NBITS - 1) * DIV + DIV / 2 + 3;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       i_clr_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_stream #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr_err   (i_clr_err),
    .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rise_at;

  logic [7:0] q[$];
  bit m_ferr;
  bit m_ovr;
  bit m_perr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input bit         stop_ok,
    input bit         bad_par,
    input int         pop_at
  );
    logic bits [NBITS];
    int   k;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_RX_PARITY_EN
    bits[9] = (^b) ^ bad_par;
`endif
    bits[NBITS-1] = stop_ok;
    rise_at = -1;
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < DIV; c++) begin
        k = i * DIV + c;
        @(negedge clk);
        if (rise_at < 0 && o_valid) rise_at = k;
        if (k == pop_at) begin
          check("pop_in_frame_valid", o_valid, 1);
          if (q.size() > 0) check("pop_in_frame", o_data, q.pop_front());
        end
        i_uart_rx = bits[i];
        i_ready   = (k == pop_at);
      end
    end
    @(negedge clk);
    i_ready = 1'b0;
    if (!stop_ok) m_ferr = 1'b1;
    if (bad_par) m_perr = 1'b1;
    if (stop_ok && !bad_par) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ferr"}, o_frame_err, m_ferr);
    check({tag, "_ovr"}, o_overrun, m_ovr);
`ifdef UART_RX_PARITY_EN
    check({tag, "_perr"}, o_parity_err, m_perr);
`endif
  endtask

  task automatic pop_expect(input string tag);
    @(negedge clk);
    if (q.size() == 0) begin
      check({tag, "_empty"}, o_valid, 0);
    end else begin
      check({tag, "_valid"}, o_valid, 1);
      check({tag, "_data"}, o_data, q.pop_front());
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_expect(tag);
    @(negedge clk);
    check({tag, "_drained"}, o_valid, 0);
  endtask

  task automatic clear_err();
    @(negedge clk);
    i_clr_err = 1'b1;
    @(negedge clk);
    i_clr_err = 1'b0;
    m_ferr = 0;
    m_ovr  = 0;
    m_perr = 0;
  endtask

  initial begin
    int busy_low;
    logic [7:0] rb;
    bit sok;
    bit bp;
    i_rst     = 1'b1;
    i_uart_rx = 1'b1;
    i_ready   = 1'b0;
    i_clr_err = 1'b0;
    m_ferr = 0;
    m_ovr  = 0;
    m_perr = 0;
    idle(3);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check_flags("rst");
    i_rst = 1'b0;
    idle(5);

    send_frame(8'h55, 1'b1, 1'b0, -1);
    check("t1_latency", (rise_at >= LAT - 1 && rise_at <= LAT + 1), 1);
    idle(8);
    check_flags("t1");
    drain("t1");

    i_uart_rx = 1'b0;
    idle(4);
    i_uart_rx = 1'b1;
    idle(40);
    check("t2_busy", o_busy, 0);
    check("t2_valid", o_valid, 0);
    check_flags("t2");

    send_frame(8'hA3, 1'b0, 1'b0, -1);
    busy_low = 0;
    repeat (48) begin
      @(negedge clk);
      if (!o_busy) busy_low++;
    end
    check("t3_busy_break", busy_low, 0);
    check("t3_valid", o_valid, 0);
    i_uart_rx = 1'b1;
    idle(16);
    check("t3_idle", o_busy, 0);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    idle(8);
    check_flags("t3");
    drain("t3");
    clear_err();
    check_flags("t3_clr");

    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, -1);
      idle(2);
    end
    check_flags("t4a");
    drain("t4a");
    clear_err();
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, -1);
      idle(2);
    end
    send_frame(8'h05, 1'b1, 1'b0, LAT - 1);
    idle(4);
    check_flags("t4b");
    drain("t4b");

    send_frame(8'h77, 1'b1, 1'b0, -1);
    send_frame(8'h11, 1'b0, 1'b0, -1);
    i_uart_rx = 1'b1;
    idle(4);
    i_uart_rx = 1'b0;
    idle(DIV * 4 + DIV / 2);
    i_uart_rx = 1'b1;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    q.delete();
    m_ferr = 0;
    m_ovr  = 0;
    m_perr = 0;
    check("t5_valid", o_valid, 0);
    check("t5_data", o_data, 0);
    check("t5_busy", o_busy, 0);
    check_flags("t5");
    idle(100);
    check("t5_quiet", o_busy, 0);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle(4);
    check_flags("t5b");
    drain("t5b");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1, -1);
    idle(4);
    check_flags("t6a");
    check("t6a_valid", o_valid, 0);
    clear_err();
    send_frame(8'h81, 1'b1, 1'b0, -1);
    idle(4);
    check_flags("t6b");
    drain("t6b");
`endif

    for (int n = 0; n < 16; n++) begin
      rb  = 8'($urandom);
      sok = ($urandom_range(0, 7) != 0);
      bp  = 1'b0;
`ifdef UART_RX_PARITY_EN
      bp  = ($urandom_range(0, 5) == 0);
`endif
      send_frame(rb, sok, bp, -1);
      i_uart_rx = 1'b1;
      idle(4);
      check_flags("rnd");
      repeat ($urandom_range(0, 2)) pop_expect("rnd");
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    drain("rnd_end");
    check_flags("rnd_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
